bin_to_bcd_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 19 +
 rtl/bin_to_bcd_seq_adjust.sv | 12 +
 rtl/bin_to_bcd_seq.sv | 101 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, the double-dabble adjust constants and a digit-count helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

  // Decimal digits of 2^w-1 = floor(w*log10(2))+1; 2^w is never a power of ten.
  function automatic int bcd_digits(input int w);
    return (w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD nibble of 5 or more before the next shift.
// Purely combinational; the sum stays within 4 bits because the input never exceeds 9.
module bcd_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] i_dig,
  output logic [3:0] o_dig
);

  assign o_dig = (i_dig >= ADJ_THRESH) ? (i_dig + ADJ_ADD) : i_dig;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: W-bit unsigned binary in, DIGITS packed BCD nibbles out.
// One bit per cycle, W cycles per conversion; valid/ready on both sides, result held until taken.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int W      = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        bin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] bcd
);

  localparam int CW = $clog2(W + 1);
  localparam int BW = 4 * DIGITS;
  localparam int RW = BW + W;

  generate
    if (W < 1 || DIGITS < bcd_digits(W)) begin : g_param_check
      $error("bin_to_bcd_seq: DIGITS=%0d too small for W=%0d", DIGITS, W);
    end
  endgenerate

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [RW-1:0]   r_work;
  logic [RW-1:0]   w_adj;
  logic [RW-1:0]   w_shift;
  logic [BW-1:0]   r_bcd;
  logic            w_accept;
  logic            w_last;

  // Binary bits below the BCD field pass through untouched; each digit is corrected in parallel.
  assign w_adj[W-1:0] = r_work[W-1:0];

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_adjust u_adj (
        .i_dig (r_work[W+4*g +: 4]),
        .o_dig (w_adj[W+4*g +: 4])
      );
    end
  endgenerate

  assign w_shift  = w_adj << 1;
  assign w_last   = (r_cnt == CW'(1));
  assign w_accept = (r_state == IDLE) && in_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = SHIFT;
      end
      SHIFT: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Output register only moves on the last shift so intermediate states never reach bcd.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_work <= '0;
      r_bcd  <= '0;
    end else if (w_accept) begin
      r_work <= {{BW{1'b0}}, bin};
      r_cnt  <= CW'(W);
    end else if (r_state == SHIFT) begin
      r_work <= w_shift;
      r_cnt  <= r_cnt - 1'b1;
      if (w_last) r_bcd <= w_shift[RW-1 -: BW];
    end
  end

  assign bcd = r_bcd;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: decimal reference model with a per-cycle compare process,
// directed literal cases, exhaustive sweep, backpressure, mid-conversion reset and a W=12 instance.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  bin;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] bcd;

  logic        in_valid_b;
  logic        in_ready_b;
  logic [11:0] bin_b;
  logic        out_valid_b;
  logic        out_ready_b;
  logic [15:0] bcd_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_cyc;

  bin_to_bcd_seq #(.W(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd)
  );

  bin_to_bcd_seq #(.W(12), .DIGITS(4)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .bin       (bin_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .bcd       (bcd_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Reference: repeated division by ten, one decimal digit per nibble.
  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    r = '0;
    for (int d = 0; d < 8; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  // Cycle-level model: a value accepted while ready appears exactly W edges later
  // and is held until out_ready; bcd keeps the last result, reset clears everything.
  bit          m_known = 1'b0;
  bit          m_ready;
  bit          m_valid;
  logic [11:0] m_bcd;
  logic [11:0] m_pend;
  int          m_left;

  always @(negedge clk) begin
    if (m_known) begin
      check("mon_in_ready",  {31'd0, in_ready},  {31'd0, m_ready});
      check("mon_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      check("mon_bcd",       {20'd0, bcd},       {20'd0, m_bcd});
    end
    if (!rst_n) begin
      m_known = 1'b1;
      m_ready = 1'b1;
      m_valid = 1'b0;
      m_bcd   = '0;
      m_left  = 0;
    end else if (m_known) begin
      if (m_ready && in_valid) begin
        m_ready = 1'b0;
        m_left  = 8;
        m_pend  = to_bcd(32'(bin))[11:0];
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_valid = 1'b1;
          m_bcd   = m_pend;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
        m_ready = 1'b1;
      end
    end
  end

  task automatic accept8(input logic [7:0] v);
    int n;
    in_valid = 1'b1;
    bin      = v;
    n        = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) timeout("accept8");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  task automatic wait_result8(output int lat, output bit ready_seen);
    int n;
    n          = 0;
    ready_seen = 1'b0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      if (in_ready) ready_seen = 1'b1;
      n++;
      @(negedge clk);
    end
    if (n >= 200) timeout("wait_result8");
    lat = cyc - acc_cyc;
  endtask

  task automatic run_b(input logic [11:0] v, input logic [15:0] exp, input string name);
    int n;
    in_valid_b = 1'b1;
    bin_b      = v;
    n          = 0;
    @(negedge clk);
    while (!in_ready_b && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) timeout("accept12");
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
    acc_cyc    = cyc;
    n          = 0;
    @(negedge clk);
    while (!out_valid_b && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) timeout("wait_result12");
    check({name, "_lat"}, 32'(cyc - acc_cyc), 32'd12);
    check(name, {16'd0, bcd_b}, {16'd0, exp});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    int  prev;
    bit  rdy;
    bit  stale;
    logic [11:0] rv;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    bin         = '0;
    out_ready   = 1'b1;
    in_valid_b  = 1'b0;
    bin_b       = '0;
    out_ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    @(negedge clk);
    check("reset_in_ready",  {31'd0, in_ready},  32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_bcd",       {20'd0, bcd},       32'h000);

    // Directed literal cases pin the model and the latency.
    accept8(8'd0);
    wait_result8(lat, rdy);
    check("zero_latency",  32'(lat), 32'd8);
    check("zero_busy_rdy", {31'd0, rdy}, 32'd0);
    check("zero_bcd",      {20'd0, bcd}, 32'h000);

    accept8(8'd255);
    wait_result8(lat, rdy);
    check("bcd_255", {20'd0, bcd}, 32'h255);
    accept8(8'd9);
    wait_result8(lat, rdy);
    check("bcd_9", {20'd0, bcd}, 32'h009);
    accept8(8'd100);
    wait_result8(lat, rdy);
    check("bcd_100", {20'd0, bcd}, 32'h100);
    @(posedge clk);
    #1;

    // Exhaustive sweep with in_valid held: results checked by the monitor, spacing here.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    prev      = 0;
    for (int v = 0; v < 256; v++) begin
      int n;
      bin = 8'(v);
      n   = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
        n++;
        @(negedge clk);
      end
      if (n >= 200) timeout("sweep_accept");
      @(posedge clk);
      #1;
      if (v > 0) check("sweep_spacing", 32'(cyc - prev), 32'd10);
      prev = cyc;
    end
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Backpressure: result held, new input ignored, then accepted after release.
    out_ready = 1'b0;
    accept8(8'd173);
    wait_result8(lat, rdy);
    check("bp_first", {20'd0, bcd}, 32'h173);
    in_valid = 1'b1;
    bin      = 8'd42;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_hold", {19'd0, out_valid, bcd}, {19'd0, 1'b1, 12'h173});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    accept8(8'd42);
    wait_result8(lat, rdy);
    check("bp_next_lat", 32'(lat), 32'd8);
    check("bp_next_bcd", {20'd0, bcd}, 32'h042);
    @(posedge clk);
    #1;

    // Reset three cycles into a conversion.
    accept8(8'd200);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_bcd",       {20'd0, bcd},       32'h000);
    check("rst_mid_in_ready",  {31'd0, in_ready},  32'd1);
    stale = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (out_valid || bcd != 12'h000) stale = 1'b1;
    end
    check("rst_no_stale", {31'd0, stale}, 32'd0);

    // Randomized traffic with stalls and occasional resets; the monitor does the checking.
    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'($urandom_range(0, 1));
      bin       = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 149) != 0);
    end
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;

    // Wider instance.
    run_b(12'd4095, 16'h4095, "w12_4095");
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      rv = 12'($urandom);
      run_b(rv, to_bcd(32'(rv))[15:0], "w12_rand");
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
